// File: rtl/red_seq_unit.sv
// red_seq_unit: multi-cycle byte-reduction engine for the RED instruction.
// One 8-bit lane is added into a 10-bit accumulator per clock. The 10-bit
// sum is published on S, sign-extended from bit 9, together with a one-cycle
// done pulse.
module red_seq_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] S
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        capture;

  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [9:0]  acc_reg;
  logic [1:0]  lane_reg;
  logic [15:0] s_reg;

  logic [7:0]  lane_byte;
  logic [9:0]  acc_sum;

  // State register; reset abandons any reduction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, handshake outputs and operand-capture strobe.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        busy = 1'b1;
        // start is ignored here so the in-progress reduction is undisturbed.
        if (lane_reg == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start in DONE launches straight into ACC with no idle bubble.
        if (start) begin
          capture    = 1'b1;
          state_next = ACC;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane selector and the single shared adder.
  always_comb begin
    lane_byte = 8'h00;
    case (lane_reg)
      2'd0:    lane_byte = a_reg[7:0];
      2'd1:    lane_byte = b_reg[7:0];
      2'd2:    lane_byte = a_reg[15:8];
      default: lane_byte = b_reg[15:8];
    endcase
    acc_sum = acc_reg + {2'b00, lane_byte};
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= 16'h0000;
      b_reg    <= 16'h0000;
      acc_reg  <= 10'd0;
      lane_reg <= 2'd0;
      s_reg    <= 16'h0000;
    end else if (capture) begin
      a_reg    <= A;
      b_reg    <= B;
      acc_reg  <= 10'd0;
      lane_reg <= 2'd0;
    end else if (state_reg == ACC) begin
      acc_reg  <= acc_sum;
      lane_reg <= lane_reg + 2'd1;
      // The sum cannot exceed 1020, so it never wraps. It is published
      // sign-extended from bit 9 to stay bit-exact with the combinational unit.
      if (lane_reg == 2'd3) begin
        s_reg <= {{6{acc_sum[9]}}, acc_sum};
      end
    end
  end

  assign S = s_reg;

endmodule

// File: tb/tb_red_seq_unit.sv
// Self-checking bench for red_seq_unit. A cycle-level reference model
// (phase counter plus arithmetic golden sum) is compared every cycle.
// Directed cases are also pinned with hand-computed literals.
module tb_red_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] S;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  red_seq_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result: sum of the four bytes, sign-extended from bit 9.
  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b);
    int          sum;
    logic [9:0]  t;
    sum = int'(a[7:0]) + int'(a[15:8]) + int'(b[7:0]) + int'(b[15:8]);
    t   = sum[9:0];
    return {{6{t[9]}}, t};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
  endtask

  // Reference model. phase 0 = idle, 1..4 = busy cycles, 5 = done cycle.
  int          m_phase;
  logic [15:0] m_s;
  logic [15:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_s     <= 16'h0000;
      m_pend  <= 16'h0000;
    end else if ((m_phase == 0 || m_phase == 5) && start) begin
      m_pend  <= golden(A, B);
      m_phase <= 1;
    end else if (m_phase >= 1 && m_phase <= 3) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == 4) begin
      m_phase <= 5;
      m_s     <= m_pend;
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("busy", {15'd0, busy}, {15'd0, (m_phase >= 1 && m_phase <= 4)});
      chk("done", {15'd0, done}, {15'd0, (m_phase == 5)});
      chk("S", S, m_s);
      chk("busy_and_done", {15'd0, (busy & done)}, 16'd0);
    end
  end

  // One reduction from IDLE: counts busy cycles, checks S on the done pulse.
  // Entered and left at posedge+2.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv);
    int  nb;
    bit  seen;
    nb    = 0;
    seen  = 0;
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #2;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        seen = 1;
        chk("op_result", S, expv);
      end
    end
    chk("op_done_seen", {15'd0, seen}, 16'd1);
    chk("op_busy_cycles", 16'(nb), 16'd4);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int t1;
    int t2;
    int ndone;

    rst   = 1'b1;
    start = 1'b0;
    A     = 16'h0000;
    B     = 16'h0000;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_S", S, 16'h0000);
    #1;
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    chk("idle_S", S, 16'h0000);

    // Basic reduction and hold.
    run_op(16'h0102, 16'h0304, 16'h000A);
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    chk("hold_S", S, 16'h000A);

    // Boundary sums.
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFC);
    run_op(16'h8080, 16'h8080, 16'hFE00);
    run_op(16'h7F7F, 16'h0000, 16'h00FE);

    // start held high with operands disturbed while busy; second launch from DONE.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    @(posedge clk);
    #2;
    A     = 16'hFFFF;
    B     = 16'hFFFF;
    t1    = 0;
    t2    = 0;
    ndone = 0;
    for (int i = 0; i < 30 && ndone < 2; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t1 = cyc;
          chk("b2b_first_S", S, 16'h000A);
        end else begin
          t2 = cyc;
          chk("b2b_second_S", S, 16'hFFFC);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 16'(ndone), 16'd2);
    chk("b2b_spacing", 16'(t2 - t1), 16'd5);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;

    // Asynchronous reset in the second busy cycle.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_done", {15'd0, done}, 16'd0);
    chk("async_rst_S", S, 16'h0000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    run_op(16'h0001, 16'h0001, 16'h0002);

    // Random operand pairs against the golden sum.
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, golden(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
